// File: rtl/nx_common_pkg.sv
// nx_common: shared types for the mesh node inbound path.
//   nx_direction_t  - source direction tag (N/E/S/W), also the RR search order
//   NX_NUM_DIRS     - number of directional streams
//   nx_dir_add()    - modulo-4 step through the directions
// NX_RST_ASSERTED(r) gives every block the same reset polarity (active low).
`ifndef NX_COMMON_PKG_SV
`define NX_COMMON_PKG_SV
`define NX_RST_ASSERTED(r) (!(r))

package nx_common;

    typedef enum logic [1:0] {
        NORTH = 2'd0,
        EAST  = 2'd1,
        SOUTH = 2'd2,
        WEST  = 2'd3
    } nx_direction_t;

    localparam int NX_NUM_DIRS = 4;

    // Two-bit add wraps naturally, giving (d + step) mod 4.
    function automatic nx_direction_t nx_dir_add(nx_direction_t d, logic [1:0] step);
        return nx_direction_t'(2'(d + step));
    endfunction

endpackage

`endif

// File: rtl/nx_fifo.sv
// nx_fifo: small inbound message FIFO, one per mesh direction.
//   clk_i, rst_i   clock, async active-low reset
//   push_i, data_i push request (taken only while ready_o=1) and message
//   pop_i          pop request (ignored while empty)
//   data_o         head message (valid whenever empty_o=0)
//   empty_o        combinational, so a message can be granted the edge after its push
//   ready_o        registered !full; held low in reset and rises on the first edge after
`include "nx_common_pkg.sv"
module nx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             ready_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [CW-1:0]               count, count_nxt;
    logic                        do_push, do_pop;

    assign do_push   = push_i && ready_o;
    assign do_pop    = pop_i && !empty_o;
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign empty_o   = (count == '0);
    assign data_o    = mem[rd_ptr];

    // Storage carries no reset; the count alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    // DEPTH is a power of two, so the pointers wrap without a compare.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (`NX_RST_ASSERTED(rst_i)) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_o <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            ready_o <= (count_nxt != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/nx_stream_arbiter.sv
// nx_stream_arbiter: buffers the four neighbour streams and round-robins them
// into one registered stream tagged with its source direction.
//   <dir>_data_i/_valid_i/_ready_o  inbound streams (north, east, south, west)
//   arb_data_o/_dir_o/_valid_o      registered output, held while stalled
//   arb_ready_i                     downstream accept
//   idle_o                          all FIFOs and the output register empty
`include "nx_common_pkg.sv"
module nx_stream_arbiter
    import nx_common::*;
#(
    parameter int STREAM_WIDTH = 32,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] north_data_i,
    input  logic                    north_valid_i,
    output logic                    north_ready_o,
    input  logic [STREAM_WIDTH-1:0] east_data_i,
    input  logic                    east_valid_i,
    output logic                    east_ready_o,
    input  logic [STREAM_WIDTH-1:0] south_data_i,
    input  logic                    south_valid_i,
    output logic                    south_ready_o,
    input  logic [STREAM_WIDTH-1:0] west_data_i,
    input  logic                    west_valid_i,
    output logic                    west_ready_o,
    output logic [STREAM_WIDTH-1:0] arb_data_o,
    output nx_direction_t           arb_dir_o,
    output logic                    arb_valid_o,
    input  logic                    arb_ready_i,
    output logic                    idle_o
);
    logic [NX_NUM_DIRS-1:0][STREAM_WIDTH-1:0] in_data, fifo_data;
    logic [NX_NUM_DIRS-1:0]                   in_valid, in_ready, fifo_empty, pop;
    nx_direction_t                            rr_ptr, gnt;
    logic                                     gnt_vld, load;

    // Index order matches nx_direction_t: 0=N, 1=E, 2=S, 3=W.
    assign in_data  = {west_data_i, south_data_i, east_data_i, north_data_i};
    assign in_valid = {west_valid_i, south_valid_i, east_valid_i, north_valid_i};
    assign {west_ready_o, south_ready_o, east_ready_o, north_ready_o} = in_ready;

    for (genvar d = 0; d < NX_NUM_DIRS; d++) begin : g_fifo
        nx_fifo #(.WIDTH(STREAM_WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .push_i (in_valid[d]),
            .data_i (in_data[d]),
            .pop_i  (pop[d]),
            .data_o (fifo_data[d]),
            .empty_o(fifo_empty[d]),
            .ready_o(in_ready[d])
        );
    end

    // Search ptr+1 .. ptr+4; the last step revisits the previous winner so a
    // lone busy stream still gets every slot.
    always_comb begin
        gnt     = rr_ptr;
        gnt_vld = 1'b0;
        for (int i = 1; i <= NX_NUM_DIRS; i++) begin
            if (!gnt_vld && !fifo_empty[nx_dir_add(rr_ptr, 2'(i))]) begin
                gnt     = nx_dir_add(rr_ptr, 2'(i));
                gnt_vld = 1'b1;
            end
        end
    end

    assign load   = gnt_vld && (!arb_valid_o || arb_ready_i);
    assign pop    = load ? (NX_NUM_DIRS'(1) << gnt) : '0;
    assign idle_o = (&fifo_empty) && !arb_valid_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (`NX_RST_ASSERTED(rst_i)) begin
            rr_ptr      <= WEST;
            arb_valid_o <= 1'b0;
            arb_data_o  <= '0;
            arb_dir_o   <= NORTH;
        end else if (load) begin
            rr_ptr      <= gnt;
            arb_valid_o <= 1'b1;
            arb_data_o  <= fifo_data[gnt];
            arb_dir_o   <= gnt;
        end else if (arb_ready_i) begin
            arb_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Directed self-checking bench for nx_stream_arbiter.
`include "nx_common_pkg.sv"
module tb_nx_stream_arbiter;
    import nx_common::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] n_d, e_d, s_d, w_d;
    logic        n_v, e_v, s_v, w_v;
    logic        n_r, e_r, s_r, w_r;
    logic [31:0] arb_data;
    logic [1:0]  arb_dir;
    logic        arb_valid, arb_ready, idle;

    int errs = 0;
    int checks = 0;
    int k;
    logic [31:0] bp_msg [4];

    always #5 clk = ~clk;

    nx_stream_arbiter #(.STREAM_WIDTH(32), .BUF_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .north_data_i(n_d), .north_valid_i(n_v), .north_ready_o(n_r),
        .east_data_i(e_d),  .east_valid_i(e_v),  .east_ready_o(e_r),
        .south_data_i(s_d), .south_valid_i(s_v), .south_ready_o(s_r),
        .west_data_i(w_d),  .west_valid_i(w_v),  .west_ready_o(w_r),
        .arb_data_o(arb_data), .arb_dir_o(arb_dir), .arb_valid_o(arb_valid),
        .arb_ready_i(arb_ready), .idle_o(idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {n_v, e_v, s_v, w_v} = 4'b0;
        {n_d, e_d, s_d, w_d} = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        arb_ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({n_r, e_r, s_r, w_r} !== 4'b0000) begin
            errs++; $display("FAIL reset_ready: got %b exp 0000", {n_r, e_r, s_r, w_r});
        end
        checks++;
        if ({arb_valid, arb_dir, arb_data, idle} !== {1'b0, 2'd0, 32'h0, 1'b1}) begin
            errs++; $display("FAIL reset_outputs: got v=%b dir=%0d d=%h idle=%b exp v=0 dir=0 d=0 idle=1",
                             arb_valid, arb_dir, arb_data, idle);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({n_r, e_r, s_r, w_r} !== 4'b0000) begin
            errs++; $display("FAIL ready_before_edge: got %b exp 0000", {n_r, e_r, s_r, w_r});
        end
        tick();
        checks++;
        if ({n_r, e_r, s_r, w_r} !== 4'b1111) begin
            errs++; $display("FAIL ready_after_release: got %b exp 1111", {n_r, e_r, s_r, w_r});
        end
        checks++;
        if ({arb_valid, idle} !== 2'b01) begin
            errs++; $display("FAIL idle_after_release: got v=%b idle=%b exp v=0 idle=1", arb_valid, idle);
        end
    endtask

    task automatic test_all_four();
        arb_ready = 1'b1;
        {n_v, e_v, s_v, w_v} = 4'b1111;
        n_d = 32'd1; e_d = 32'd2; s_d = 32'd3; w_d = 32'd4;
        tick();
        idle_inputs();
        checks++;
        if ({arb_valid, idle} !== 2'b00) begin
            errs++; $display("FAIL all4_after_push: got v=%b idle=%b exp v=0 idle=0", arb_valid, idle);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({arb_valid, arb_dir, arb_data} !== {1'b1, 2'(i), 32'(i + 1)}) begin
                errs++; $display("FAIL all4_order[%0d]: got v=%b dir=%0d d=%h exp v=1 dir=%0d d=%h",
                                 i, arb_valid, arb_dir, arb_data, i, i + 1);
            end
        end
        tick();
        checks++;
        if ({arb_valid, idle} !== 2'b01) begin
            errs++; $display("FAIL all4_drain: got v=%b idle=%b exp v=0 idle=1", arb_valid, idle);
        end
        checks++;
        if (dut.rr_ptr !== WEST) begin
            errs++; $display("FAIL all4_ptr: got %0d exp 3", dut.rr_ptr);
        end
    endtask

    task automatic test_single();
        arb_ready = 1'b1;
        n_d = 32'hDEADBEEF;
        n_v = 1'b1;
        tick();
        n_v = 1'b0;
        checks++;
        if (arb_valid !== 1'b0) begin
            errs++; $display("FAIL single_early: got v=%b exp v=0", arb_valid);
        end
        tick();
        checks++;
        if ({arb_valid, arb_dir, arb_data} !== {1'b1, 2'd0, 32'hDEADBEEF}) begin
            errs++; $display("FAIL single_out: got v=%b dir=%0d d=%h exp v=1 dir=0 d=deadbeef",
                             arb_valid, arb_dir, arb_data);
        end
        tick();
        checks++;
        if ({arb_valid, idle} !== 2'b01) begin
            errs++; $display("FAIL single_idle: got v=%b idle=%b exp v=0 idle=1", arb_valid, idle);
        end
    endtask

    // One east-sender cycle: push happens only if ready was high before the edge.
    task automatic east_step();
        logic rdy;
        rdy = e_r;
        tick();
        if (e_v && rdy) k++;
        e_v = (k < 4);
        if (k < 4) e_d = bp_msg[k];
    endtask

    task automatic test_backpressure();
        bp_msg[0] = 32'hE000_0001; bp_msg[1] = 32'hE000_0002;
        bp_msg[2] = 32'hE000_0003; bp_msg[3] = 32'hE000_0004;
        arb_ready = 1'b0;
        k = 0;
        e_v = 1'b1;
        e_d = bp_msg[0];
        for (int c = 1; c <= 6; c++) begin
            east_step();
            if (c >= 2) begin
                checks++;
                if ({arb_valid, arb_dir, arb_data} !== {1'b1, 2'd1, bp_msg[0]}) begin
                    errs++; $display("FAIL bp_hold[%0d]: got v=%b dir=%0d d=%h exp v=1 dir=1 d=%h",
                                     c, arb_valid, arb_dir, arb_data, bp_msg[0]);
                end
            end
        end
        checks++;
        if (k !== 3 || e_r !== 1'b0) begin
            errs++; $display("FAIL bp_full: got pushed=%0d ready=%b exp pushed=3 ready=0", k, e_r);
        end
        arb_ready = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            east_step();
            checks++;
            if ({arb_valid, arb_dir, arb_data} !== {1'b1, 2'd1, bp_msg[j]}) begin
                errs++; $display("FAIL bp_release[%0d]: got v=%b dir=%0d d=%h exp v=1 dir=1 d=%h",
                                 j, arb_valid, arb_dir, arb_data, bp_msg[j]);
            end
        end
        tick();
        checks++;
        if ({arb_valid, idle} !== 2'b01 || k !== 4) begin
            errs++; $display("FAIL bp_drain: got v=%b idle=%b pushed=%0d exp v=0 idle=1 pushed=4",
                             arb_valid, idle, k);
        end
        idle_inputs();
    endtask

    task automatic test_fairness();
        int nseq, sseq, nexp, sexp;
        logic nr, sr;
        logic [1:0] prev;
        nseq = 0; sseq = 0; nexp = 0; sexp = 0; prev = 2'd0;
        arb_ready = 1'b1;
        n_v = 1'b1; s_v = 1'b1;
        n_d = 32'h1000_0000; s_d = 32'h3000_0000;
        for (int c = 1; c <= 100; c++) begin
            nr = n_r; sr = s_r;
            tick();
            if (nr) begin nseq++; n_d = 32'h1000_0000 + 32'(nseq); end
            if (sr) begin sseq++; s_d = 32'h3000_0000 + 32'(sseq); end
            if (c >= 2) begin
                checks++;
                if (arb_valid !== 1'b1) begin
                    errs++; $display("FAIL fair_valid[%0d]: got v=%b exp v=1", c, arb_valid);
                end else if (arb_dir === 2'd0) begin
                    if (arb_data !== 32'h1000_0000 + 32'(nexp)) begin
                        errs++; $display("FAIL fair_ndata[%0d]: got %h exp %h", c, arb_data,
                                         32'h1000_0000 + 32'(nexp));
                    end
                    nexp++;
                end else if (arb_dir === 2'd2) begin
                    if (arb_data !== 32'h3000_0000 + 32'(sexp)) begin
                        errs++; $display("FAIL fair_sdata[%0d]: got %h exp %h", c, arb_data,
                                         32'h3000_0000 + 32'(sexp));
                    end
                    sexp++;
                end else begin
                    errs++; $display("FAIL fair_dir[%0d]: got %0d exp 0 or 2", c, arb_dir);
                end
                if (c >= 3) begin
                    checks++;
                    if (arb_dir === prev) begin
                        errs++; $display("FAIL fair_alternate[%0d]: got dir=%0d exp not %0d", c, arb_dir, prev);
                    end
                end
                prev = arb_dir;
            end
        end
        checks++;
        if (nexp < 45 || sexp < 45) begin
            errs++; $display("FAIL fair_starve: got n=%0d s=%0d exp both >=45", nexp, sexp);
        end
        idle_inputs();
        repeat (5) tick();
        checks++;
        if (idle !== 1'b1) begin
            errs++; $display("FAIL fair_drain: got idle=%b exp 1", idle);
        end
    endtask

    task automatic test_reset_mid();
        arb_ready = 1'b0;
        n_v = 1'b1; e_v = 1'b1;
        n_d = 32'hA000_0001; e_d = 32'hB000_0001;
        tick();
        n_d = 32'hA000_0002; e_d = 32'hB000_0002;
        tick();
        idle_inputs();
        checks++;
        if ({arb_valid, idle} !== 2'b10) begin
            errs++; $display("FAIL mid_setup: got v=%b idle=%b exp v=1 idle=0", arb_valid, idle);
        end
        #3;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({arb_valid, arb_data, arb_dir, idle} !== {1'b0, 32'h0, 2'd0, 1'b1}) begin
            errs++; $display("FAIL mid_async: got v=%b d=%h dir=%0d idle=%b exp v=0 d=0 dir=0 idle=1",
                             arb_valid, arb_data, arb_dir, idle);
        end
        checks++;
        if ({n_r, e_r, s_r, w_r} !== 4'b0000) begin
            errs++; $display("FAIL mid_ready: got %b exp 0000", {n_r, e_r, s_r, w_r});
        end
        tick();
        rst_i = 1'b1;
        arb_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({arb_valid, idle} !== 2'b01) begin
                errs++; $display("FAIL mid_stale[%0d]: got v=%b idle=%b exp v=0 idle=1", c, arb_valid, idle);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_single();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
